// File: rtl/clk_div_pkg.sv
// Shared types and constants for the multi-channel clock divider.
// Contents:
//   clk_div_state_e     - per-channel FSM states (IDLE, HIGH, LOW)
//   CLKDIV_MIN_RATIO    - smallest ratio that divides; 0 and 1 select bypass
//   CLKDIV_DEF_RATIO_W  - default width of a ratio field and of a channel counter
package clk_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } clk_div_state_e;

  localparam int unsigned CLKDIV_MIN_RATIO   = 2;
  localparam int unsigned CLKDIV_DEF_RATIO_W = 8;

endpackage : clk_div_pkg

// File: rtl/clk_div_ch.sv
// One divider channel: FSM, phase counter, shadow ratio, tick and bypass mux.
// Optional macro CLKDIV_IDLE_GATE_EN: an IDLE channel whose enable is low
// drives 0 instead of bypassing the reference clock.
// Ports:
//   I_ref_clk   - reference clock
//   I_rst       - synchronous active-high reset
//   I_clk_en    - divide enable
//   I_div_ratio - requested ratio, sampled only at period boundaries
//   I_sync      - restart pulse shared by all channels
//   O_div_clk   - divided clock, or I_ref_clk while idle
//   O_tick      - registered pulse in the first cycle of each high phase
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int unsigned RATIO_W = CLKDIV_DEF_RATIO_W
) (
  input  logic               I_ref_clk,
  input  logic               I_rst,
  input  logic               I_clk_en,
  input  logic [RATIO_W-1:0] I_div_ratio,
  input  logic               I_sync,
  output logic               O_div_clk,
  output logic               O_tick
);

  localparam logic [RATIO_W-1:0] MIN_R = RATIO_W'(CLKDIV_MIN_RATIO);
  localparam logic [RATIO_W-1:0] ONE   = RATIO_W'(1);

  clk_div_state_e     state_q, state_d;
  logic [RATIO_W-1:0] cnt_q,   cnt_d;
  logic [RATIO_W-1:0] ratio_q, ratio_d;
  logic               tick_q,  tick_d;

  logic [RATIO_W-1:0] high_len;
  logic [RATIO_W-1:0] low_len;
  logic               ratio_ok;

  // Odd ratios give the extra cycle to the low phase.
  assign high_len = ratio_q >> 1;
  assign low_len  = ratio_q - high_len;
  assign ratio_ok = (I_div_ratio >= MIN_R);

  // State register.
  always_ff @(posedge I_ref_clk) begin
    if (I_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ratio_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ratio_q <= ratio_d;
      tick_q  <= tick_d;
    end
  end

  // Next-state logic; a sync pulse overrides counting and the period-end decision.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ratio_d = ratio_q;
    tick_d  = 1'b0;

    if (I_sync && (state_q != ST_IDLE)) begin
      // An invalid ratio at sync keeps the old one so the phases stay non-zero.
      state_d = ST_HIGH;
      cnt_d   = '0;
      tick_d  = 1'b1;
      if (ratio_ok) ratio_d = I_div_ratio;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (I_clk_en && ratio_ok) begin
            state_d = ST_HIGH;
            ratio_d = I_div_ratio;
            tick_d  = 1'b1;
          end
        end
        ST_HIGH: begin
          if (cnt_q == high_len - ONE) begin
            state_d = ST_LOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        ST_LOW: begin
          if (cnt_q == low_len - ONE) begin
            cnt_d = '0;
            if (I_clk_en && ratio_ok) begin
              state_d = ST_HIGH;
              ratio_d = I_div_ratio;
              tick_d  = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output mux: divided level while running, reference clock (or 0) while idle.
  always_comb begin
    O_div_clk = I_ref_clk;
    unique case (state_q)
      ST_HIGH: O_div_clk = 1'b1;
      ST_LOW:  O_div_clk = 1'b0;
      default: begin
`ifdef CLKDIV_IDLE_GATE_EN
        O_div_clk = I_clk_en ? I_ref_clk : 1'b0;
`else
        O_div_clk = I_ref_clk;
`endif
      end
    endcase
  end

  assign O_tick = tick_q;

endmodule : clk_div_ch

// File: rtl/clk_div_multi.sv
// Multi-channel integer clock divider: NUM_CH independent channels sharing one
// reference clock, reset and phase-alignment pulse.
// Optional macro CLKDIV_IDLE_GATE_EN: gate idle, disabled channels to 0.
// Ports:
//   I_ref_clk   - reference clock
//   I_rst       - synchronous active-high reset
//   I_clk_en    - per-channel divide enable
//   I_div_ratio - channel c ratio at [c*RATIO_W +: RATIO_W]
//   I_sync      - one-cycle pulse restarting all running channels in phase
//   O_div_clk   - per-channel divided clock
//   O_tick      - per-channel pulse at the start of each high phase
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned RATIO_W = CLKDIV_DEF_RATIO_W
) (
  input  logic                      I_ref_clk,
  input  logic                      I_rst,
  input  logic [NUM_CH-1:0]         I_clk_en,
  input  logic [NUM_CH*RATIO_W-1:0] I_div_ratio,
  input  logic                      I_sync,
  output logic [NUM_CH-1:0]         O_div_clk,
  output logic [NUM_CH-1:0]         O_tick
);

  // One divider per channel; I_sync fans out to all of them.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    clk_div_ch #(
      .RATIO_W (RATIO_W)
    ) u_ch (
      .I_ref_clk   (I_ref_clk),
      .I_rst       (I_rst),
      .I_clk_en    (I_clk_en[c]),
      .I_div_ratio (I_div_ratio[c*RATIO_W +: RATIO_W]),
      .I_sync      (I_sync),
      .O_div_clk   (O_div_clk[c]),
      .O_tick      (O_tick[c])
    );
  end

endmodule : clk_div_multi

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: directed scenarios followed by random
// stimulus, all compared against a period-position reference model.
module tb_clk_div_multi;

  localparam int NCH = 2;
  localparam int RW  = 8;

  logic              clk   = 1'b0;
  logic              rst   = 1'b1;
  logic [NCH-1:0]    en    = '0;
  logic [NCH*RW-1:0] ratio = '0;
  logic              sync  = 1'b0;
  logic [NCH-1:0]    div_clk;
  logic [NCH-1:0]    tick;

  int errors = 0;
  int checks = 0;
  int tick_cnt [NCH];

  // Reference model: a running channel sits at position pos within a period of r cycles.
  bit          m_run [NCH];
  int unsigned m_r   [NCH];
  int unsigned m_pos [NCH];

  always #5 clk = ~clk;

  clk_div_multi #(.NUM_CH(NCH), .RATIO_W(RW)) dut (
    .I_ref_clk   (clk),
    .I_rst       (rst),
    .I_clk_en    (en),
    .I_div_ratio (ratio),
    .I_sync      (sync),
    .O_div_clk   (div_clk),
    .O_tick      (tick)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned ratio_of(input int c);
    logic [RW-1:0] v;
    v = ratio[c*RW +: RW];
    return int'(v);
  endfunction

  // Advance the model by one reference edge using the currently driven inputs.
  function automatic void model_edge();
    for (int c = 0; c < NCH; c++) begin
      int unsigned rq;
      bit ok;
      rq = ratio_of(c);
      ok = (rq >= 2);
      if (rst) begin
        m_run[c] = 0; m_r[c] = 0; m_pos[c] = 0;
      end else if (m_run[c] && sync) begin
        if (ok) m_r[c] = rq;
        m_pos[c] = 0;
      end else if (m_run[c]) begin
        m_pos[c]++;
        if (m_pos[c] == m_r[c]) begin
          m_pos[c] = 0;
          if (en[c] && ok) m_r[c] = rq;
          else m_run[c] = 0;
        end
      end else if (en[c] && ok) begin
        m_run[c] = 1; m_r[c] = rq; m_pos[c] = 0;
      end
    end
  endfunction

  function automatic logic exp_clk(input int c, input logic ref_lvl);
    if (m_run[c]) return (m_pos[c] < (m_r[c] >> 1));
`ifdef CLKDIV_IDLE_GATE_EN
    if (!en[c]) return 1'b0;
`endif
    return ref_lvl;
  endfunction

  // One reference cycle: check just after the rising edge and at the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("ch%0d_div_clk_hi", c), 32'(div_clk[c]), 32'(exp_clk(c, 1'b1)));
      check($sformatf("ch%0d_tick", c), 32'(tick[c]), 32'(m_run[c] && m_pos[c] == 0));
      if (tick[c] === 1'b1) tick_cnt[c]++;
    end
    @(negedge clk);
    for (int c = 0; c < NCH; c++)
      check($sformatf("ch%0d_div_clk_lo", c), 32'(div_clk[c]), 32'(exp_clk(c, 1'b0)));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Run until channel c shows a tick, bounded.
  task automatic wait_tick(input int c);
    int n;
    n = 0;
    while (tick[c] !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    check($sformatf("ch%0d_wait_tick_timeout", c), 32'(n < 300), 32'd1);
  endtask

  initial begin
    for (int c = 0; c < NCH; c++) begin
      m_run[c] = 0; m_r[c] = 0; m_pos[c] = 0; tick_cnt[c] = 0;
    end

    // Reset state: idle, no ticks, bypass.
    rst = 1'b1;
    steps(3);
    check("reset_tick", 32'(tick), 32'd0);

    // ratio 4 on ch0, ratio 5 on ch1: tick counts over 20 cycles.
    en = 2'b11;
    ratio[7:0]  = 8'd4;
    ratio[15:8] = 8'd5;
    rst = 1'b0;
    for (int c = 0; c < NCH; c++) tick_cnt[c] = 0;
    steps(20);
    check("ch0_ticks_r4", 32'(tick_cnt[0]), 32'd5);
    check("ch1_ticks_r5", 32'(tick_cnt[1]), 32'd4);

    // ch1 ratio 1 then 0: bypass after the current period.
    ratio[15:8] = 8'd1;
    steps(8);
    ratio[15:8] = 8'd0;
    for (int c = 0; c < NCH; c++) tick_cnt[c] = 0;
    steps(8);
    check("ch1_bypass_no_ticks", 32'(tick_cnt[1]), 32'd0);

    // ch0 ratio 4 -> 6 one cycle into the high phase.
    wait_tick(0);
    step();
    ratio[7:0] = 8'd6;
    steps(16);

    // Drop enable during the high phase of a ratio-6 period.
    wait_tick(0);
    en[0] = 1'b0;
    steps(10);
    check("ch0_disabled_idle_tick", 32'(tick[0]), 32'd0);

    // Sync two running channels at arbitrary phases.
    en = 2'b11;
    ratio[7:0]  = 8'd4;
    ratio[15:8] = 8'd6;
    steps(10 + int'($urandom_range(0, 7)));
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("sync_both_tick", 32'(tick), 32'd3);
    steps(24);

    // Reset in the low phase of a ratio-8 period, then restart.
    ratio[7:0] = 8'd8;
    steps(8);
    wait_tick(0);
    steps(5);
    rst = 1'b1;
    step();
    check("rst_mid_low_tick", 32'(tick), 32'd0);
    rst = 1'b0;
    step();
    check("rst_release_tick", 32'(tick[0]), 32'd1);
    steps(10);

    // Random stimulus.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 7) == 0)
          ratio[c*RW +: RW] = ($urandom_range(0, 49) == 0) ? RW'($urandom_range(13, 40))
                                                           : RW'($urandom_range(0, 12));
        if ($urandom_range(0, 19) == 0) en[c] = ~en[c];
      end
      sync = ($urandom_range(0, 39) == 0);
      rst  = ($urandom_range(0, 199) == 0);
      step();
    end
    sync = 1'b0;
    rst  = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_clk_div_multi
